// File: rtl/touch_pkg.sv
// touch_pkg
// Shared constants and the FSM state type for the touchscreen sample filter.
//   LCD_WIDTH / LCD_HEIGHT : visible screen size in pixels
//   ADC_BITS               : width of the raw touchscreen coordinates
//   ACC_BITS               : width of the per-axis sample accumulators
//   PIX_X_BITS / PIX_Y_BITS: widths of the screen column / row outputs
package touch_pkg;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;
  localparam int ADC_BITS   = 12;
  localparam int ACC_BITS   = 15;
  localparam int PIX_X_BITS = $clog2(LCD_WIDTH);
  localparam int PIX_Y_BITS = $clog2(LCD_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } touch_state_t;

endpackage

// File: rtl/touch_axis_scale.sv
// touch_axis_scale
// Combinational window check and ADC-to-pixel scaling for one axis.
//   avg      : averaged raw coordinate
//   in_range : avg lies inside [MIN, MAX]
//   pix      : ((avg - MIN) * K) >> ADC_BITS, saturated to W-1,
//              where K = ceil(W * 2^ADC_BITS / (MAX - MIN))
// K is folded to a constant at elaboration, so only a constant multiply
// remains in hardware.
module touch_axis_scale
  import touch_pkg::*;
#(
  parameter int MIN   = 256,
  parameter int MAX   = 3840,
  parameter int W     = 240,
  parameter int PIX_W = $clog2(W)
) (
  input  logic [ACC_BITS-1:0] avg,
  output logic                in_range,
  output logic [PIX_W-1:0]    pix
);

  localparam int SPAN    = MAX - MIN;
  localparam int SCALE_K = (W * (1 << ADC_BITS) + SPAN - 1) / SPAN;

  localparam logic [ACC_BITS-1:0] MIN_V = ACC_BITS'(MIN);
  localparam logic [ACC_BITS-1:0] MAX_V = ACC_BITS'(MAX);
  localparam logic [31:0]         TOP_V = 32'(W - 1);

  logic [ACC_BITS-1:0] offset;
  logic [31:0]         product;
  logic [31:0]         scaled;

  // The offset is meaningless when avg is below MIN, but the caller
  // discards the point in that case, so no guard is needed here.
  always_comb begin
    in_range = (avg >= MIN_V) && (avg <= MAX_V);
    offset   = avg - MIN_V;
    product  = 32'(offset) * 32'(SCALE_K);
    scaled   = product >> ADC_BITS;
    if (scaled > TOP_V) begin
      pix = PIX_W'(W - 1);
    end else begin
      pix = scaled[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/touch_sample_filter.sv
// touch_sample_filter
// Averages groups of 2^N_AVG_LOG2 raw touchscreen samples, rejects points
// outside the valid ADC window, scales them to LCD pixels and hands them
// downstream over a valid/ready handshake. A pen-up gap of TIMEOUT_CYCLES
// closes the current stroke and pulses stroke_end if the stroke produced
// at least one point.
//   clk, reset_n      : clock, asynchronous active-low reset
//   en                : enables sample acceptance
//   pos_ready         : one-cycle strobe qualifying x_pos / y_pos
//   x_pos, y_pos      : raw ADC coordinates
//   pix_valid         : pix_x / pix_y hold a point awaiting pix_ready
//   pix_ready         : downstream accepts the point
//   pix_x, pix_y      : screen column (0..239) and row (0..319)
//   stroke_end        : one-cycle end-of-stroke pulse
module touch_sample_filter
  import touch_pkg::*;
#(
  parameter int N_AVG_LOG2     = 2,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int X_MIN          = 256,
  parameter int X_MAX          = 3840,
  parameter int Y_MIN          = 256,
  parameter int Y_MAX          = 3840
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  pos_ready,
  input  logic [ADC_BITS-1:0]   x_pos,
  input  logic [ADC_BITS-1:0]   y_pos,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIX_X_BITS-1:0] pix_x,
  output logic [PIX_Y_BITS-1:0] pix_y,
  output logic                  stroke_end
);

  localparam int                CNT_W    = N_AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'((1 << N_AVG_LOG2) - 1);
  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  touch_state_t state_q, state_d;

  logic [ACC_BITS-1:0]   acc_x, acc_y;
  logic [ACC_BITS-1:0]   avg_x, avg_y;
  logic [CNT_W-1:0]      sample_cnt;
  logic [TO_W-1:0]       idle_cnt;
  logic                  stroke_open;
  logic                  point_sent;
  logic                  collecting, accept, last_sample, timeout;
  logic                  x_ok, y_ok;
  logic [PIX_X_BITS-1:0] scaled_x;
  logic [PIX_Y_BITS-1:0] scaled_y;

  assign collecting  = (state_q == IDLE) || (state_q == ACCUM);
  assign accept      = pos_ready && en && collecting;
  assign last_sample = accept && (sample_cnt == LAST_IDX);
  // An accepted sample in the same cycle as the limit keeps the stroke alive.
  assign timeout     = stroke_open && collecting && !accept && (idle_cnt == TO_LIMIT);

  assign avg_x = acc_x >> N_AVG_LOG2;
  assign avg_y = acc_y >> N_AVG_LOG2;

  touch_axis_scale #(
    .MIN   (X_MIN),
    .MAX   (X_MAX),
    .W     (LCD_WIDTH),
    .PIX_W (PIX_X_BITS)
  ) u_scale_x (
    .avg      (avg_x),
    .in_range (x_ok),
    .pix      (scaled_x)
  );

  touch_axis_scale #(
    .MIN   (Y_MIN),
    .MAX   (Y_MAX),
    .W     (LCD_HEIGHT),
    .PIX_W (PIX_Y_BITS)
  ) u_scale_y (
    .avg      (avg_y),
    .in_range (y_ok),
    .pix      (scaled_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (last_sample) begin
          state_d = SCALE;
        end else if (accept) begin
          state_d = ACCUM;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      SCALE: begin
        state_d = (x_ok && y_ok) ? OUTPUT : IDLE;
      end
      OUTPUT: begin
        if (pix_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulation, pen-up timing, stroke bookkeeping and output registers.
  // The idle counter is frozen while a point is being scaled or handed off,
  // so a slow consumer never causes a spurious stroke_end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x       <= '0;
      acc_y       <= '0;
      sample_cnt  <= '0;
      idle_cnt    <= '0;
      stroke_open <= 1'b0;
      point_sent  <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      stroke_end  <= 1'b0;
    end else begin
      stroke_end <= 1'b0;

      if (accept) begin
        acc_x       <= acc_x + ACC_BITS'(x_pos);
        acc_y       <= acc_y + ACC_BITS'(y_pos);
        sample_cnt  <= sample_cnt + 1'b1;
        idle_cnt    <= '0;
        stroke_open <= 1'b1;
      end else if (timeout) begin
        acc_x       <= '0;
        acc_y       <= '0;
        sample_cnt  <= '0;
        idle_cnt    <= '0;
        stroke_open <= 1'b0;
        point_sent  <= 1'b0;
        stroke_end  <= point_sent;
      end else if (stroke_open && collecting) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (state_q == SCALE) begin
        acc_x      <= '0;
        acc_y      <= '0;
        sample_cnt <= '0;
        if (x_ok && y_ok) begin
          pix_x     <= scaled_x;
          pix_y     <= scaled_y;
          pix_valid <= 1'b1;
        end
      end

      if ((state_q == OUTPUT) && pix_ready) begin
        pix_valid  <= 1'b0;
        point_sent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_touch_sample_filter.sv
// tb_touch_sample_filter
// Self-checking bench for touch_sample_filter. Expected points come from a
// reference model that averages each group of four samples with plain
// integer arithmetic and applies the window/scale/saturate rules.
module tb_touch_sample_filter;
  import touch_pkg::*;

  localparam int TO   = 60;
  localparam int XMIN = 256;
  localparam int XMAX = 3840;
  localparam int YMIN = 256;
  localparam int YMAX = 3840;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       en        = 1'b0;
  logic       pos_ready = 1'b0;
  logic       pix_ready = 1'b0;
  logic [11:0] x_pos    = '0;
  logic [11:0] y_pos    = '0;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [8:0] pix_y;
  logic       stroke_end;

  int checks = 0;
  int errors = 0;
  int stroke_end_seen = 0;
  int valid_seen = 0;
  int sx[4];
  int sy[4];

  always #5 clk = ~clk;

  touch_sample_filter #(
    .N_AVG_LOG2     (2),
    .TIMEOUT_CYCLES (TO),
    .X_MIN          (XMIN),
    .X_MAX          (XMAX),
    .Y_MIN          (YMIN),
    .Y_MAX          (YMAX)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .pos_ready  (pos_ready),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .stroke_end (stroke_end)
  );

  always @(negedge clk) begin
    if (stroke_end === 1'b1) stroke_end_seen++;
    if (pix_valid === 1'b1) valid_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] x, input logic [11:0] y);
    x_pos     = x;
    y_pos     = y;
    pos_ready = 1'b1;
    tick();
    pos_ready = 1'b0;
  endtask

  // Reference: window check, ceil-derived scale factor, truncation, saturation.
  function automatic void ref_axis(input int avg, input int mn, input int mx,
                                   input int w, output bit ok, output int pix);
    int k;
    ok  = (avg >= mn) && (avg <= mx);
    k   = (w * 4096 + (mx - mn) - 1) / (mx - mn);
    pix = 0;
    if (ok) begin
      pix = ((avg - mn) * k) / 4096;
      if (pix > w - 1) pix = w - 1;
    end
  endfunction

  // Sends sx/sy as four pulses and checks the resulting point (or its
  // absence). With hold set, the consumer stalls for ten cycles while more
  // pulses arrive, and the point must not move.
  task automatic run_group(input string tag, input int gap, input bit hold);
    int  ax = 0;
    int  ay = 0;
    int  ex, ey;
    bit  okx, oky;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(12'(sx[i]), 12'(sy[i]));
      ax += sx[i];
      ay += sy[i];
      if (i < 3) repeat (gap) tick();
    end
    ax = ax / 4;
    ay = ay / 4;
    ref_axis(ax, XMIN, XMAX, LCD_WIDTH, okx, ex);
    ref_axis(ay, YMIN, YMAX, LCD_HEIGHT, oky, ey);
    check_output({tag, "_lat1"}, 32'(pix_valid), 32'd0);
    tick();
    if (okx && oky) begin
      check_output({tag, "_valid"}, 32'(pix_valid), 32'd1);
      check_output({tag, "_x"}, 32'(pix_x), 32'(ex));
      check_output({tag, "_y"}, 32'(pix_y), 32'(ey));
      if (hold) begin
        for (int c = 0; c < 10; c++) begin
          apply_stimulus(12'($urandom_range(300, 3800)), 12'($urandom_range(300, 3800)));
          check_output({tag, "_hold_v"}, 32'(pix_valid), 32'd1);
          check_output({tag, "_hold_x"}, 32'(pix_x), 32'(ex));
          check_output({tag, "_hold_y"}, 32'(pix_y), 32'(ey));
        end
      end
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      check_output({tag, "_done"}, 32'(pix_valid), 32'd0);
    end else begin
      check_output({tag, "_drop"}, 32'(pix_valid), 32'd0);
      tick();
      check_output({tag, "_drop2"}, 32'(pix_valid), 32'd0);
    end
  endtask

  task automatic fill(input int x0, input int x1, input int x2, input int x3,
                      input int y0, input int y1, input int y2, input int y3);
    sx[0] = x0; sx[1] = x1; sx[2] = x2; sx[3] = x3;
    sy[0] = y0; sy[1] = y1; sy[2] = y2; sy[3] = y3;
  endtask

  initial begin
    int base_se;
    int base_v;
    int bx, by;

    // Reset values while reset_n is held low.
    #2;
    check_output("rst_valid", 32'(pix_valid), 32'd0);
    check_output("rst_x", 32'(pix_x), 32'd0);
    check_output("rst_y", 32'(pix_y), 32'd0);
    check_output("rst_se", 32'(stroke_end), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    en      = 1'b1;
    tick();

    fill(2048, 2048, 2048, 2048, 1024, 1024, 1024, 1024);
    run_group("mid", 0, 1'b0);
    check_output("mid_const_x", 32'(pix_x), 32'd120);

    fill(3840, 3840, 3840, 3840, 3840, 3840, 3840, 3840);
    run_group("sat", 1, 1'b0);
    check_output("sat_const_y", 32'(pix_y), 32'd319);

    fill(1000, 1002, 1004, 1006, 3000, 3001, 3002, 3003);
    run_group("trunc", 0, 1'b0);

    fill(256, 256, 256, 256, 3840, 3840, 3840, 3840);
    run_group("edge_min", 1, 1'b0);

    fill(100, 100, 100, 100, 2000, 2000, 2000, 2000);
    run_group("oor", 0, 1'b0);
    fill(2048, 2048, 2048, 2048, 1024, 1024, 1024, 1024);
    run_group("after_oor", 2, 1'b0);

    fill(255, 255, 255, 255, 2000, 2000, 2000, 2000);
    run_group("edge_xlow", 0, 1'b0);
    fill(1500, 1500, 1500, 1500, 3841, 3841, 3841, 3841);
    run_group("edge_yhigh", 0, 1'b0);

    // Pulses with en low must be ignored entirely.
    en = 1'b0;
    base_v = valid_seen;
    for (int i = 0; i < 4; i++) apply_stimulus(12'd3000, 12'd3000);
    repeat (3) tick();
    check_output("en_off", 32'(valid_seen - base_v), 32'd0);
    en = 1'b1;
    fill(700, 710, 720, 730, 2500, 2400, 2300, 2200);
    run_group("en_on", 0, 1'b0);

    for (int g = 0; g < 8; g++) begin
      bx = int'($urandom_range(0, 4095));
      by = int'($urandom_range(0, 4095));
      for (int i = 0; i < 4; i++) begin
        sx[i] = bx + int'($urandom_range(0, 40));
        sy[i] = by + int'($urandom_range(0, 40));
        if (sx[i] > 4095) sx[i] = 4095;
        if (sy[i] > 4095) sy[i] = 4095;
      end
      run_group("rand", int'($urandom_range(0, 2)), 1'b0);
    end

    fill(1500, 1500, 1500, 1500, 2500, 2500, 2500, 2500);
    run_group("hold", 0, 1'b1);
    fill(3000, 3010, 3020, 3030, 600, 610, 620, 630);
    run_group("after_hold", 0, 1'b0);

    // Stroke with a transferred point: exactly one stroke_end, not early.
    base_se = stroke_end_seen;
    repeat (TO - 5) tick();
    check_output("to_early", 32'(stroke_end_seen - base_se), 32'd0);
    repeat (30) tick();
    check_output("to_once", 32'(stroke_end_seen - base_se), 32'd1);

    // Partial group then timeout: nothing comes out, partial is discarded.
    base_se = stroke_end_seen;
    base_v  = valid_seen;
    apply_stimulus(12'd400, 12'd400);
    apply_stimulus(12'd400, 12'd400);
    repeat (TO + 30) tick();
    check_output("partial_se", 32'(stroke_end_seen - base_se), 32'd0);
    check_output("partial_v", 32'(valid_seen - base_v), 32'd0);
    fill(2048, 2048, 2048, 2048, 1024, 1024, 1024, 1024);
    run_group("after_partial", 0, 1'b0);

    // Reset in the middle of accumulation clears everything immediately.
    apply_stimulus(12'd3000, 12'd500);
    apply_stimulus(12'd3000, 12'd500);
    apply_stimulus(12'd3000, 12'd500);
    base_se = stroke_end_seen;
    reset_n = 1'b0;
    #1;
    check_output("midrst_valid", 32'(pix_valid), 32'd0);
    check_output("midrst_x", 32'(pix_x), 32'd0);
    check_output("midrst_y", 32'(pix_y), 32'd0);
    check_output("midrst_se", 32'(stroke_end), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    fill(1200, 1200, 1200, 1200, 2200, 2200, 2200, 2200);
    run_group("post_rst", 0, 1'b0);
    check_output("post_rst_se", 32'(stroke_end_seen - base_se), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_sample_filter.md
TOUCH_SAMPLE_FILTER -- requirements
Module: touch_sample_filter

Interface
REQ-001 Parameter N_AVG_LOG2, default 2, sets the samples averaged per point (4).
REQ-002 Parameter TIMEOUT_CYCLES, default 500000, sets the pen-up gap in clk cycles that ends a stroke (10 ms at 50 MHz).
REQ-003 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 256/3840/256/3840, set the valid raw ADC window per axis.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: high enables sample acceptance.
REQ-007 Port pos_ready, input, 1: single-cycle pulse from the touchscreen driver marking a valid x_pos/y_pos.
REQ-008 Ports x_pos and y_pos, input, 12 each: raw ADC coordinates, sampled only when pos_ready=1.
REQ-009 Port pix_valid, output, 1: the scaled point on pix_x/pix_y is valid.
REQ-010 Port pix_ready, input, 1: the downstream consumer accepts the point.
REQ-011 Port pix_x, output, 8: screen column, 0..239.
REQ-012 Port pix_y, output, 9: screen row, 0..319.
REQ-013 Port stroke_end, output, 1: single-cycle pulse marking the end of a stroke.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM, SCALE, OUTPUT.
REQ-015 A sample is accepted when pos_ready=1, en=1 and state is IDLE or ACCUM.
- Accepting adds x_pos/y_pos into 15-bit accumulators and increments the sample counter.
- Accepting in IDLE moves to ACCUM.
REQ-016 The accept that brings the count to 2^N_AVG_LOG2 SHALL move the FSM to SCALE.
REQ-017 In SCALE, the average SHALL be accumulator >> N_AVG_LOG2 (truncating); for example 1000, 1002, 1004, 1006 average to 1003.
REQ-018 If either average lies outside its [MIN, MAX] window, the point SHALL be discarded.
- Accumulators and counter clear; FSM returns to IDLE; pix_valid is not asserted.
REQ-019 In-range scaling SHALL be pix = ((avg - MIN) * SCALE) >> 12, saturated to W-1.
- SCALE = ceil(W*4096/(MAX-MIN)).
- W = 240 for x, 320 for y.
REQ-020 For an in-range point, SCALE SHALL register pix_x/pix_y, set pix_valid=1, clear the accumulators and move to OUTPUT.
- pix_valid is high two cycles after the cycle containing the final accepted pos_ready.
REQ-021 In OUTPUT, pix_valid, pix_x and pix_y SHALL hold stable until a cycle with pix_ready=1.
- That cycle completes the transfer; pix_valid is 0 the next cycle; FSM goes to IDLE.
REQ-022 pos_ready pulses arriving in SCALE or OUTPUT SHALL be dropped, not buffered.
REQ-023 Pen-up timeout counter behaviour:
- Clears on every accepted sample.
- Counts in IDLE/ACCUM while a stroke is open.
- Freezes in SCALE/OUTPUT.
REQ-024 A stroke opens on the first accepted sample after reset or after a stroke_end.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the block SHALL:
- discard any partial accumulation and return to IDLE;
- close the stroke;
- pulse stroke_end for one cycle, but only if at least one point was transferred in that stroke.
REQ-026 If pos_ready is accepted in the same cycle the timeout is reached, the sample SHALL win.
- The counter clears; no stroke_end is generated.
REQ-027 While en=0, no samples are accepted and the timeout counter keeps running.
- A pending OUTPUT transfer still completes under the normal handshake.

Reset
REQ-028 reset_n=0 SHALL asynchronously force:
- FSM to IDLE;
- accumulators, sample counter and timeout counter to 0;
- stroke to closed;
- pix_valid=0, pix_x=0, pix_y=0, stroke_end=0.
REQ-029 Reset asserted mid-accumulation or mid-handshake SHALL drop all state with no stroke_end; release is synchronous to clk.

Structure
REQ-030 Package touch_pkg SHALL hold LCD_WIDTH=240, LCD_HEIGHT=320, ADC_BITS=12 and the FSM state enumeration.
REQ-031 Per-axis window check, scaling and saturation SHALL live in sub-module touch_axis_scale.
- It is parameterised by MIN, MAX and W.
- It is instantiated once per axis.
REQ-032 The block SHALL use no RAM and no divider: SCALE is an elaborated constant.

Verification
REQ-033 Four pulses x=2048/y=1024 -> pix_valid 2 cycles after the 4th pulse, with pix_x=120, pix_y=68.
REQ-034 Four pulses x=3840/y=3840 -> pix_x=239, pix_y=319 (saturation).
REQ-035 Four pulses x=100/y=2000 -> no pix_valid; FSM back to IDLE; the next valid group is processed normally.
REQ-036 Hold pix_ready=0 for 10 cycles while pulsing pos_ready -> outputs are stable and the extra pulses are dropped; then pix_ready=1 for one cycle -> pix_valid=0 next cycle.
REQ-037 One point transferred, then no pulses for TIMEOUT_CYCLES -> exactly one stroke_end pulse.
- Two pulses then timeout -> no pix_valid and no stroke_end.
REQ-038 Assert reset_n=0 after the 3rd pulse -> all outputs 0 immediately.
- After release, four fresh pulses produce a correct point unaffected by the earlier samples.
